updi_rx_buffer: RTL and testbench

// - Sits directly downstream of the UART receiver; consumes its rx_data / rx_data_valid / rx_error pulses.
// - Queues received characters with a per-entry error flag in a first-word-fall-through FIFO for the UPDI

---
 rtl/updi_rx_buffer.sv | 180 ++++++++++++++++++
 tb/tb_updi_rx_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_rx_buffer.sv
// updi_rx_buffer
// Receive-side buffer for a UPDI link.
// - Queues UART receiver characters, with a per-entry error flag, in a
//   first-word-fall-through FIFO.
// - Runs a response timer that fires after TIMEOUT_CYCLES clocks of line silence.
// - Optional echo filter, enabled with the macro UPDI_RX_ECHO_FILTER_EN, drops
//   the self-echo of bytes driven onto the single-wire line.
module updi_rx_buffer #(
    parameter int DATA_BITS      = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_BITS-1:0]         in_data,
    input  logic                         in_valid,
    input  logic                         in_error,
    output logic [DATA_BITS-1:0]         out_data,
    output logic                         out_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         timeout_arm,
    output logic                         timeout,
    input  logic                         echo_load,
    input  logic [7:0]                   echo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Storage: {err, data} per entry. Read is combinational so the head falls through.
    logic [DATA_BITS:0]  r_mem [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;

    state_t              r_state;
    state_t              w_state_next;
    logic [TW-1:0]       r_tcnt;
    logic [TW-1:0]       w_tcnt_next;
    logic                r_timeout;
    logic                w_timeout_next;

    logic                w_rx;
    logic                w_discard;
    logic                w_full;
    logic                w_pop;
    logic                w_accept;
    logic                w_push;
    logic                w_drop;
    logic [DATA_BITS:0]  w_wentry;

    // Any receiver strobe is line activity; an error strobe wins over a data strobe.
    assign w_rx     = in_valid | in_error;
    assign w_wentry = in_error ? {1'b1, {DATA_BITS{1'b0}}} : {1'b0, in_data};
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = (r_count != '0) & out_ready;
    assign w_accept = w_rx & ~w_discard;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push   = w_accept & (~w_full | w_pop);
    assign w_drop   = w_accept & w_full & ~w_pop;

`ifdef UPDI_RX_ECHO_FILTER_EN
    logic [7:0] r_echo_cnt;
    logic [7:0] w_echo_next;

    // Echo counter: a load overrides the running count and may itself consume the coincident push.
    always_comb begin
        w_echo_next = r_echo_cnt;
        w_discard   = 1'b0;
        if (echo_load) begin
            w_discard   = w_rx && (echo_count != 8'd0);
            w_echo_next = w_discard ? (echo_count - 8'd1) : echo_count;
        end else if (w_rx && (r_echo_cnt != 8'd0)) begin
            w_discard   = 1'b1;
            w_echo_next = r_echo_cnt - 8'd1;
        end
    end

    // Echo counter register; flush abandons any pending echo.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_echo_cnt <= 8'd0;
        end else begin
            r_echo_cnt <= w_echo_next;
        end
    end
`else
    logic w_unused_echo;
    assign w_unused_echo = ^{echo_load, echo_count};
    assign w_discard     = 1'b0;
`endif

    // FIFO control: pointers wrap naturally, occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_push) begin
            r_mem[r_wr_ptr] <= w_wentry;
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tcnt    <= w_tcnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Timer next state: arm beats expiry, line activity beats expiry, flush beats all.
    always_comb begin
        w_state_next   = r_state;
        w_tcnt_next    = r_tcnt;
        w_timeout_next = 1'b0;
        if (flush) begin
            w_state_next = S_IDLE;
            w_tcnt_next  = '0;
        end else if (timeout_arm) begin
            w_state_next = S_WAIT;
            w_tcnt_next  = '0;
        end else if (r_state == S_WAIT) begin
            if (w_rx) begin
                w_tcnt_next = '0;
            end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                w_timeout_next = 1'b1;
                w_state_next   = S_IDLE;
                w_tcnt_next    = '0;
            end else begin
                w_tcnt_next = r_tcnt + 1'b1;
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr][DATA_BITS-1:0] : '0;
    assign out_err   = out_valid ? r_mem[r_rd_ptr][DATA_BITS] : 1'b0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_updi_rx_buffer.sv
// Testbench for updi_rx_buffer (DEPTH=16, TIMEOUT_CYCLES=8).
// Table-driven FIFO vectors, hand-written overflow/full/timer/echo sequences,
// and a randomized run checked against a queue-based reference model.
module tb_updi_rx_buffer;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int TC    = 8;

    logic          clk;
    logic          rst_n;
    logic [DB-1:0] in_data;
    logic          in_valid;
    logic          in_error;
    logic [DB-1:0] out_data;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [4:0]    count;
    logic          overflow;
    logic          timeout_arm;
    logic          timeout;
    logic          echo_load;
    logic [7:0]    echo_count;

    updi_rx_buffer #(.DATA_BITS(DB), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_error(in_error), .out_data(out_data), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .count(count), .overflow(overflow), .timeout_arm(timeout_arm),
        .timeout(timeout), .echo_load(echo_load), .echo_count(echo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs set before tick() are sampled at the next posedge; outputs are read 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_data = '0; in_valid = 0; in_error = 0; out_ready = 0; flush = 0;
        timeout_arm = 0; echo_load = 0; echo_count = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic push(input logic [7:0] d);
        in_data = d; in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] d;
        logic       rdy;
        logic       fl;
        int         cnt;
        logic       val;
        logic [7:0] hd;
        logic       he;
        logic       ovf;
    } vec_t;

    vec_t tbl[14];

    // Timer helper: arm, then step up to 40 clocks; optionally a byte or re-arm at clock n.
    task automatic run_timer(input int byte_at, input int arm_at, output int pulse_at);
        pulse_at = -1;
        timeout_arm = 1;
        tick();
        timeout_arm = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == byte_at) begin in_valid = 1; in_data = 8'h5A; end
            if (n == arm_at) timeout_arm = 1;
            tick();
            in_valid = 0; timeout_arm = 0;
            if (timeout) begin
                pulse_at = n;
                break;
            end
        end
        tick();
        chk("timeout_one_clk", timeout, 0);
    endtask

    logic [8:0] q[$];
    logic       m_ovf;
    int         pulse;
    int         npulse;

    initial begin
        clr_in();
        rst_n = 0;
        tick();
        tick();
        // Reset state
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", out_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1;

        // ---------------- table-driven FIFO vectors ----------------
        //           v  e  d      rdy fl  cnt val hd     he ovf
        tbl[0]  = '{1, 0, 8'h55, 0, 0, 1, 1, 8'h55, 0, 0};
        tbl[1]  = '{1, 0, 8'hA3, 0, 0, 2, 1, 8'h55, 0, 0};
        tbl[2]  = '{1, 0, 8'h0F, 0, 0, 3, 1, 8'h55, 0, 0};
        tbl[3]  = '{0, 0, 8'h00, 1, 0, 2, 1, 8'hA3, 0, 0};
        tbl[4]  = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h0F, 0, 0};
        tbl[5]  = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};
        tbl[6]  = '{0, 1, 8'h99, 0, 0, 1, 1, 8'h00, 1, 0};
        tbl[7]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[8]  = '{1, 0, 8'h3C, 1, 0, 1, 1, 8'h3C, 0, 0};
        tbl[9]  = '{1, 0, 8'h11, 1, 0, 1, 1, 8'h11, 0, 0};
        tbl[10] = '{1, 1, 8'hAB, 0, 0, 2, 1, 8'h11, 0, 0};
        tbl[11] = '{0, 0, 8'h00, 1, 0, 1, 1, 8'h00, 1, 0};
        tbl[12] = '{1, 0, 8'h5A, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[13] = '{0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v; in_error = tbl[i].e; in_data = tbl[i].d;
            out_ready = tbl[i].rdy; flush = tbl[i].fl;
            tick();
            clr_in();
            chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].val);
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].hd);
            chk($sformatf("vec%0d_err", i), out_err, tbl[i].he);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
            $display("vector %0d: count=%0d valid=%0d data=0x%02h err=%0d ovf=%0d",
                     i, count, out_valid, out_data, out_err, overflow);
        end

        // ---------------- overflow: 17 pushes, no pops ----------------
        do_reset();
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_read%0d", i), out_data, 8'h80 + 8'(i));
            out_ready = 1;
            tick();
            out_ready = 0;
        end
        chk("ovf_drained", count, 0);
        chk("ovf_sticky", overflow, 1);
        flush = 1; tick(); flush = 0;
        chk("ovf_flush_clr", overflow, 0);
        $display("overflow sequence done");

        // ---------------- full FIFO, push+pop same cycle ----------------
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        in_data = 8'h77; in_valid = 1; out_ready = 1;
        tick();
        clr_in();
        chk("full_pp_count", count, 16);
        chk("full_pp_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_read%0d", i), out_data, (i == 15) ? 8'h77 : 8'h21 + 8'(i));
            out_ready = 1;
            tick();
            out_ready = 0;
        end
        chk("full_drained", count, 0);
        $display("full push+pop sequence done");

        // ---------------- reset mid-operation ----------------
        push(8'h01); push(8'h02);
        do_reset();
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);

        // ---------------- timer ----------------
        run_timer(0, 0, pulse);
        chk("timer_silent", pulse, 8);
        $display("timer silent: pulse at %0d", pulse);
        run_timer(5, 0, pulse);
        chk("timer_byte5", pulse, 13);
        $display("timer byte@5: pulse at %0d", pulse);
        run_timer(0, 8, pulse);
        chk("timer_rearm", pulse, 16);
        $display("timer rearm@8: pulse at %0d", pulse);
        timeout_arm = 1; tick(); timeout_arm = 0;
        tick(); tick(); tick();
        flush = 1; tick(); flush = 0;
        npulse = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (timeout) npulse++;
        end
        chk("timer_flush_stop", npulse, 0);
        $display("timer flush: %0d pulses", npulse);

        // ---------------- echo filter ----------------
        do_reset();
        echo_load = 1; echo_count = 8'd2;
        tick();
        clr_in();
        push(8'h55); push(8'h44); push(8'h12);
`ifdef UPDI_RX_ECHO_FILTER_EN
        chk("echo_count", count, 1);
        chk("echo_head", out_data, 8'h12);
`else
        chk("echo_count", count, 3);
        chk("echo_head", out_data, 8'h55);
`endif
        $display("echo: count=%0d head=0x%02h", count, out_data);

        // ---------------- randomized vs queue model ----------------
        do_reset();
        q.delete();
        m_ovf = 0;
        for (int c = 0; c < 600; c++) begin
            logic       rv, re, rr, rf, pop_m;
            logic [7:0] rd;
            rv = ($urandom_range(0, 9) < 6);
            re = ($urandom_range(0, 9) == 0);
            rr = (c < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            rf = ($urandom_range(0, 59) == 0);
            rd = 8'($urandom);
            in_valid = rv; in_error = re; in_data = rd; out_ready = rr; flush = rf;
            // Reference: flush clears; else pop head if any, push unless full without a pop.
            if (rf) begin
                q.delete();
                m_ovf = 0;
            end else begin
                pop_m = (q.size() > 0) && rr;
                if (rv || re) begin
                    if (q.size() == DEPTH && !pop_m) m_ovf = 1;
                    else q.push_back(re ? 9'h100 : {1'b0, rd});
                end
                if (pop_m) void'(q.pop_front());
            end
            tick();
            clr_in();
            chk("rnd_count", count, q.size());
            chk("rnd_valid", out_valid, q.size() > 0);
            chk("rnd_ovf", overflow, m_ovf);
            if (q.size() > 0) begin
                chk("rnd_data", out_data, q[0][7:0]);
                chk("rnd_err", out_err, q[0][8]);
            end
        end
        $display("random run done: %0d cycles", 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
